vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates the raster scan for the VGA path on the 50 MHz system clock.
//  Produces DrawX/DrawY and the blank flag that the color mapper consumes.
//  Produces the hs/vs syncs, delayed so they line up with the color mapper's registered RGB.
//  Also produces a per-pixel enable and frame/line pulses, which game logic uses to step tank
//  and bullet motion once per frame.
// PARAMETERS
//  CLK_DIV    2    clk cycles per pixel (50 MHz -> 25 MHz pixel rate); must be >=1
//  H_VISIBLE  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync width, pixels
//  H_BACK     48   horizontal back porch, pixels (H_TOTAL=800, must be <=1024)
//  V_VISIBLE  480  visible lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vertical sync width, lines
//  V_BACK     33   vertical back porch, lines (V_TOTAL=525, must be <=1024)
//  SYNC_POL   0    asserted level of hs/vs (0 = active-low)
//  PIPE_DLY   1    clk cycles of delay applied to hs/vs only; range 0..4
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  reset_n      in   1   synchronous reset, active-low
//  pixel_en     out  1   one-clk pulse, once per pixel period
//  DrawX        out  10  current pixel column (= hc)
//  DrawY        out  10  current pixel row (= vc)
//  blank        out  1   1 = visible region (hc<H_VISIBLE && vc<V_VISIBLE), 0 = blanked
//  hs           out  1   horizontal sync, delayed PIPE_DLY clks
//  vs           out  1   vertical sync, delayed PIPE_DLY clks
//  line_start   out  1   one-clk pulse when the counters advance to hc=0
//  frame_start  out  1   one-clk pulse when the counters advance to hc=0, vc=0
//  frame_count  out  16  count of completed frames, wraps 16'hFFFF->0
// BEHAVIOUR
//  Registers: div_cnt, hc[9:0], vc[9:0], the sync delay line, frame_count, and the pulses.
//  - Reset (sampled while reset_n=0):
//      div_cnt=0, hc=0, vc=0, frame_count=0.
//      pixel_en=0, line_start=0, frame_start=0.
//      hs=vs=~SYNC_POL, and every delay-line stage is filled with ~SYNC_POL.
//  - Reset mid-frame: the counters restart at (0,0) on the next edge; no partial sync pulse is
//    emitted afterwards.
//  - Pixel enable:
//      div_cnt counts 0..CLK_DIV-1 and then wraps to 0.
//      pixel_en = (div_cnt==CLK_DIV-1), combinational from div_cnt.
//      With CLK_DIV=1, pixel_en is constantly 1 out of reset.
//  - Counters, updated only on edges where pixel_en=1:
//      hc==H_TOTAL-1 -> hc<=0, and vc advances; otherwise hc<=hc+1.
//      vc==V_TOTAL-1 (when hc wraps) -> vc<=0; otherwise vc<=vc+1.
//  - Timing with CLK_DIV=2: after reset releases at cycle 0, hc=N holds during clk cycles 2N and 2N+1.
//  - DrawX, DrawY and blank are combinational from hc/vc with zero latency, so the color mapper's
//    one-cycle output register lines up with hs/vs when PIPE_DLY=1.
//  - Raw syncs:
//      hs_raw asserted for hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
//      vs_raw asserted for vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
//      vs_raw changes only at hc=0.
//  - hs/vs are hs_raw/vs_raw passed through PIPE_DLY clk-rate flops. PIPE_DLY=0 means they are combinational.
//  - line_start/frame_start are registered.
//      line_start=1 on the clk after an edge where pixel_en=1 and hc==H_TOTAL-1.
//      frame_start additionally requires vc==V_TOTAL-1.
//      frame_count increments on the same edge that sets frame_start.
//      line_start and frame_start coincide at a frame boundary.
//  - Outputs never take X or undefined values; all counter compares are unsigned and 10-bit.
// TESTING
//  T1 Reset, CLK_DIV=2:
//     release reset_n at cycle 0 -> pixel_en high on cycles 1,3,5...
//     DrawX=0 on cycles 0-1, DrawX=1 on cycles 2-3, blank=1.
//  T2 Horizontal timing:
//     hs (PIPE_DLY=1) falls at cycle 1313 and rises at cycle 1505 (96 pixels = 192 clks).
//     blank falls at cycle 1280 (hc=640).
//     line_start pulse at cycle 1600, when DrawX=0 and DrawY=1.
//  T3 Vertical timing:
//     vs is low for exactly 2 lines (3200 clks), starting 1 clk after vc reaches 490.
//     blank=0 for every clk with vc in 480..524.
//  T4 Frame wrap:
//     frame_start pulses once per 840000 clks, coincident with line_start.
//     frame_count reads 1, 2, 3.
//     Force frame_count to 16'hFFFF -> the next frame_start gives 0.
//  T5 Mid-frame reset:
//     hold reset_n=0 for 1 clk at hc=700, vc=300 (inside hs).
//     -> next clk: DrawX=0, DrawY=0, hs=vs=1 after the delay line flushes, frame_count=0.
//  T6 Parameters CLK_DIV=1, PIPE_DLY=0, SYNC_POL=1:
//     pixel_en constantly 1; hs high (asserted) combinationally on cycles 656..751.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster-scan outputs of the VGA timing generator: pixel coordinates, blanking, syncs and
// the per-pixel / per-line / per-frame strobes.
interface vga_timing_gen_if;
    logic        pixel_en;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output pixel_en, DrawX, DrawY, blank, hs, vs,
               line_start, frame_start, frame_count
    );

    modport slave (
        input  pixel_en, DrawX, DrawY, blank, hs, vs,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides the system clock down to the pixel rate, scans hc/vc across the
// frame and emits blanking, pipelined syncs and line/frame strobes for the color mapper.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned PIPE_DLY  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned FC_W     = 16;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic [FC_W-1:0]  frame_count;
    logic             line_start;
    logic             frame_start;

    logic pixel_en_c;
    logic h_last_c;
    logic v_last_c;
    logic hs_raw_c;
    logic vs_raw_c;
    logic hs_c;
    logic vs_c;

    assign pixel_en_c = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_last_c   = (hc == CNT_W'(H_TOTAL - 1));
    assign v_last_c   = (vc == CNT_W'(V_TOTAL - 1));

    // Raw syncs decode straight from the counters; vc only moves at hc wrap so vs_raw follows suit.
    assign hs_raw_c = ((hc >= CNT_W'(HS_START)) && (hc <= CNT_W'(HS_END))) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw_c = ((vc >= CNT_W'(VS_START)) && (vc <= CNT_W'(VS_END))) ? SYNC_POL : ~SYNC_POL;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= pixel_en_c ? '0 : div_cnt + DIV_W'(1);
            line_start  <= pixel_en_c && h_last_c;
            frame_start <= pixel_en_c && h_last_c && v_last_c;
            if (pixel_en_c) begin
                if (h_last_c) begin
                    hc <= '0;
                    if (v_last_c) begin
                        vc          <= '0;
                        frame_count <= frame_count + FC_W'(1);
                    end else begin
                        vc <= vc + CNT_W'(1);
                    end
                end else begin
                    hc <= hc + CNT_W'(1);
                end
            end
        end
    end

    // Sync delay line matches the color mapper's registered RGB; reset flushes it to idle.
    if (PIPE_DLY == 0) begin : g_no_dly
        assign hs_c = hs_raw_c;
        assign vs_c = vs_raw_c;
    end else begin : g_dly
        logic [PIPE_DLY-1:0] hs_pipe;
        logic [PIPE_DLY-1:0] vs_pipe;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                hs_pipe <= {PIPE_DLY{~SYNC_POL}};
                vs_pipe <= {PIPE_DLY{~SYNC_POL}};
            end else begin
                hs_pipe[0] <= hs_raw_c;
                vs_pipe[0] <= vs_raw_c;
                for (int i = 1; i < int'(PIPE_DLY); i++) begin
                    hs_pipe[i] <= hs_pipe[i-1];
                    vs_pipe[i] <= vs_pipe[i-1];
                end
            end
        end

        assign hs_c = hs_pipe[PIPE_DLY-1];
        assign vs_c = vs_pipe[PIPE_DLY-1];
    end

    assign vga.pixel_en    = pixel_en_c;
    assign vga.DrawX       = hc;
    assign vga.DrawY       = vc;
    assign vga.blank       = (hc < CNT_W'(H_VISIBLE)) && (vc < CNT_W'(V_VISIBLE));
    assign vga.hs          = hs_c;
    assign vga.vs          = vs_c;
    assign vga.line_start  = line_start;
    assign vga.frame_start = frame_start;
    assign vga.frame_count = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing, a shrunken frame for vertical/frame behaviour,
// and the CLK_DIV=1 / PIPE_DLY=0 / active-high-sync variant, checked against a cycle-number model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pe;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int   dut;
        int   cyc;
        obs_t exp;
    } vec_t;

    localparam int NCYC = 1610;

    logic clk = 1'b0;
    logic rst_def;
    logic rst_sml;
    logic rst_p6;
    int   errors = 0;
    int   checks = 0;

    vec_t vecs[$];
    vec_t sb[$];
    obs_t hist[3][NCYC];

    always #5 clk = ~clk;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sml ();
    vga_timing_gen_if if_p6 ();

    vga_timing_gen u_def (
        .clk     (clk),
        .reset_n (rst_def),
        .vga     (if_def)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b0), .PIPE_DLY(2)
    ) u_sml (
        .clk     (clk),
        .reset_n (rst_sml),
        .vga     (if_sml)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DLY(0)
    ) u_p6 (
        .clk     (clk),
        .reset_n (rst_p6),
        .vga     (if_p6)
    );

    function automatic obs_t mk(input int pe, input int x, input int y, input int b,
                                input int hs, input int vs, input int ls, input int fs,
                                input int fc);
        obs_t o;
        o.pe    = 1'(pe);
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.blank = 1'(b);
        o.hs    = 1'(hs);
        o.vs    = 1'(vs);
        o.ls    = 1'(ls);
        o.fs    = 1'(fs);
        o.fc    = 16'(fc);
        return o;
    endfunction

    function automatic obs_t grab(input int d);
        obs_t o;
        case (d)
            0: o = {if_def.pixel_en, if_def.DrawX, if_def.DrawY, if_def.blank, if_def.hs,
                    if_def.vs, if_def.line_start, if_def.frame_start, if_def.frame_count};
            1: o = {if_sml.pixel_en, if_sml.DrawX, if_sml.DrawY, if_sml.blank, if_sml.hs,
                    if_sml.vs, if_sml.line_start, if_sml.frame_start, if_sml.frame_count};
            default: o = {if_p6.pixel_en, if_p6.DrawX, if_p6.DrawY, if_p6.blank, if_p6.hs,
                    if_p6.vs, if_p6.line_start, if_p6.frame_start, if_p6.frame_count};
        endcase
        return o;
    endfunction

    // Expected outputs at cycle t after reset release, derived from t alone.
    function automatic obs_t model(input int d, input int t);
        int dv, hv, hf, hsw, ht, vv, vf, vsw, vt, p;
        int pix, hcn, vcn, tp, hcp, vcp, tq;
        logic pol;
        obs_t o;
        dv = 2; hv = 640; hf = 16; hsw = 96; ht = 800;
        vv = 480; vf = 10; vsw = 2; vt = 525; p = 1; pol = 1'b0;
        if (d == 1) begin
            hv = 8; hf = 2; hsw = 3; ht = 16; vv = 6; vf = 2; vsw = 2; vt = 12; p = 2;
        end else if (d == 2) begin
            dv = 1; p = 0; pol = 1'b1;
        end
        pix = t / dv;
        hcn = pix % ht;
        vcn = (pix / ht) % vt;
        o.pe    = ((t % dv) == dv - 1);
        o.x     = 10'(hcn);
        o.y     = 10'(vcn);
        o.blank = (hcn < hv) && (vcn < vv);
        tp = t - p;
        if (tp < 0) begin
            o.hs = ~pol;
            o.vs = ~pol;
        end else begin
            hcp = (tp / dv) % ht;
            vcp = (tp / dv / ht) % vt;
            o.hs = (hcp >= hv + hf && hcp < hv + hf + hsw) ? pol : ~pol;
            o.vs = (vcp >= vv + vf && vcp < vv + vf + vsw) ? pol : ~pol;
        end
        tq = t - 1;
        o.ls = (t >= 1) && ((tq % dv) == dv - 1) && (((tq / dv) % ht) == ht - 1);
        o.fs = o.ls && (((tq / dv / ht) % vt) == vt - 1);
        o.fc = 16'(t / (dv * ht * vt));
        return o;
    endfunction

    task automatic chk(input string name, input int d, input int t, input obs_t got,
                       input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc%0d: got pe=%b x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want pe=%b x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                     name, d, t, got.pe, got.x, got.y, got.blank, got.hs, got.vs, got.ls,
                     got.fs, got.fc, exp.pe, exp.x, exp.y, exp.blank, exp.hs, exp.vs,
                     exp.ls, exp.fs, exp.fc);
        end
    endtask

    // Push expectations when the cycle starts, pop and compare at mid-cycle.
    task automatic sweep(input int n, input bit [2:0] mask);
        vec_t ent;
        obs_t got;
        for (int t = 0; t < n; t++) begin
            if (t > 0) @(posedge clk);
            for (int d = 0; d < 3; d++)
                if (mask[d]) sb.push_back('{d, t, model(d, t)});
            if (t > 0) @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (mask[d]) begin
                    ent = sb.pop_front();
                    got = grab(ent.dut);
                    if (ent.cyc < NCYC) hist[ent.dut][ent.cyc] = got;
                    chk("sweep", ent.dut, ent.cyc, got, ent.exp);
                end
            end
        end
    endtask

    initial begin
        bit   found;
        obs_t got;

        vecs.push_back('{0, 0,    mk(0, 0,   0, 1, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 1,    mk(1, 0,   0, 1, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 2,    mk(0, 1,   0, 1, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 3,    mk(1, 1,   0, 1, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 1279, mk(1, 639, 0, 1, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 1280, mk(0, 640, 0, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 1312, mk(0, 656, 0, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 1313, mk(1, 656, 0, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{0, 1504, mk(0, 752, 0, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{0, 1505, mk(1, 752, 0, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 1599, mk(1, 799, 0, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 1600, mk(0, 0,   1, 1, 1, 1, 1, 0, 0)});
        vecs.push_back('{2, 0,    mk(1, 0,   0, 1, 0, 0, 0, 0, 0)});
        vecs.push_back('{2, 655,  mk(1, 655, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{2, 656,  mk(1, 656, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{2, 751,  mk(1, 751, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{2, 752,  mk(1, 752, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{2, 800,  mk(1, 0,   1, 1, 0, 0, 1, 0, 0)});
        vecs.push_back('{1, 21,   mk(1, 10,  0, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{1, 22,   mk(0, 11,  0, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{1, 27,   mk(1, 13,  0, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{1, 28,   mk(0, 14,  0, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{1, 257,  mk(1, 0,   8, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{1, 258,  mk(0, 1,   8, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1, 321,  mk(1, 0,  10, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1, 322,  mk(0, 1,  10, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{1, 383,  mk(1, 15, 11, 0, 1, 1, 0, 0, 0)});
        vecs.push_back('{1, 384,  mk(0, 0,   0, 1, 1, 1, 1, 1, 1)});
        vecs.push_back('{1, 768,  mk(0, 0,   0, 1, 1, 1, 1, 1, 2)});
        vecs.push_back('{1, 1152, mk(0, 0,   0, 1, 1, 1, 1, 1, 3)});

        rst_def = 1'b0;
        rst_sml = 1'b0;
        rst_p6  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_def = 1'b1;
        rst_sml = 1'b1;
        rst_p6  = 1'b1;

        sweep(NCYC, 3'b111);

        foreach (vecs[i])
            chk($sformatf("vec%0d", i), vecs[i].dut, vecs[i].cyc,
                hist[vecs[i].dut][vecs[i].cyc], vecs[i].exp);

        // One-clock reset in the middle of an hs pulse, mid-frame.
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (if_sml.DrawX == 10'd11 && if_sml.DrawY == 10'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_wait: got no hc=11 vc=3 within 600 clks, want reached");
        end else begin
            checks++;
            if (if_sml.hs !== 1'b0) begin
                errors++;
                $display("FAIL midreset_in_hs: got hs=%b, want 0", if_sml.hs);
            end
            rst_sml = 1'b0;
            @(negedge clk);
            rst_sml = 1'b1;
            got = grab(1);
            chk("midreset_c0", 1, 0, got, mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
            sweep(400, 3'b010);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
